// File: rtl/gate_truth_table_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer: FSM state encoding
// and the field layout of the 8-bit result word.
package gate_truth_table_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int RES_W       = 8;
    localparam int RES_AB_LSB  = 6;
    localparam int RES_OUT_LSB = 3;
    localparam int RES_EXP_LSB = 0;

endpackage

// File: rtl/gate_truth_table_sequencer_expected.sv
// Golden behaviour of the 2-input gate bank: [0]=buf(a), [1]=nand(a,b), [2]=xnor(a,b).
module gate_expected_model (
    input  logic       a_i,
    input  logic       b_i,
    output logic [2:0] exp_o
);

    assign exp_o = {~(a_i ^ b_i), ~(a_i & b_i), a_i};

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Clocked stimulus/capture engine: sweeps the four (a,b) vectors into the gate
// bank, samples its outputs after a settle time and emits one checked result per vector.
module gate_truth_table_sequencer
    import gate_truth_table_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             a,
    output logic             b,
    input  logic [2:0]       dut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic             res_mismatch,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [PASS_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_q, a_d, b_q, b_d;
    logic               vld_q, vld_d;
    logic [RES_W-1:0]   data_q, data_d;
    logic               mis_q, mis_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [2:0]         exp_w;
    logic               mis_w;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    gate_expected_model u_expected (
        .a_i  (a_q),
        .b_i  (b_q),
        .exp_o(exp_w)
    );

    // Case-inequality so unknown bits from the gate bank count as failures.
    assign mis_w = (dut_out !== exp_w);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        vld_d   = vld_q;
        data_d  = data_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    pass_d  = '0;
                    err_d   = '0;
                end
            end
            S_DRIVE: begin
                a_d     = idx_q[1];
                b_d     = idx_q[0];
                cnt_d   = CNT_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_SAMPLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_SAMPLE: begin
                data_d = '0;
                data_d[RES_AB_LSB  +: 2] = {a_q, b_q};
                data_d[RES_OUT_LSB +: 3] = dut_out;
                data_d[RES_EXP_LSB +: 3] = exp_w;
                mis_d   = mis_w;
                if (mis_w) err_d = sat_inc(err_q);
                vld_d   = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (res_ready) begin
                    vld_d = 1'b0;
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_DRIVE;
                    end else if (pass_q != LAST_PASS) begin
                        idx_d   = '0;
                        pass_d  = pass_q + PASS_W'(1);
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign a            = a_q;
    assign b            = b_q;
    assign res_valid    = vld_q;
    assign res_data     = data_q;
    assign res_mismatch = mis_q;
    assign err_count    = err_q;

endmodule
